eth_reg_arbiter: RTL and testbench
==================================

Name: eth_reg_arbiter

Overview:
- Shares the single KSZ8851 register-access engine (offset/length/WR/writeData/NewCommand out; state/readData in) among NUM_REQ requesters: init sequencer, TX path, RX path, interrupt service.
- Accepts one register command per requester, issues it to the engine, tracks completion via the engine state code, and returns read data with a one-cycle done pulse.
- Includes round-robin fairness, an init-exclusive mode and a watchdog timeout.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 is the init sequencer.
- TIMEOUT, 1024, cycles allowed per ISSUE or BUSY phase before abort.
- TW, 11, width of timeout counter (must satisfy 2^TW > TIMEOUT).

Ports:
- sysclk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- init_mode  in  1  when high, only requester 0 may be granted.
- req  in  NUM_REQ  per-requester command request, level; held until done.
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_offset  in  8*NUM_REQ  register offset; slice i = [8i+7:8i].
- req_length  in  NUM_REQ  engine length bit.
- req_wdata  in  16*NUM_REQ  write data; slice i = [16i+15:16i].
- gnt  out  NUM_REQ  one-hot grant, high from issue through completion.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse coincident with done on timeout abort.
- rdata  out  16  read data, valid on done for reads; held until the next read completes.
- offset  out  8  to engine.
- length  out  1  to engine.
- WR  out  1  to engine.
- writeData  out  16  to engine; 0 for reads.
- NewCommand  out  1  to engine, command strobe.
- state  in  4  engine state: Addr0=0, Read1=4, Read2=5, Write1=7, Write2=8, Wait=9.
- readData  in  16  engine read data.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; rr_ptr = 0; timeout counter = 0. Reset mid-transaction aborts silently, with no done or err pulse.
- FSM states:
  - IDLE: pick a winner among eligible req bits (eligible = req & (init_mode ? 1 : all ones)). Search starts at rr_ptr and wraps modulo NUM_REQ. On a winner: latch its wr/offset/length/wdata into the engine outputs, set gnt one-hot, NewCommand <= 1, go to ISSUE. Issue occurs on the cycle after the req is sampled.
  - ISSUE: hold NewCommand and the engine outputs stable until state != Wait (accepted). Then NewCommand <= 0 and go to BUSY.
  - BUSY: when state == Wait (engine returned), perform the following in the same cycle, then return to IDLE:
    - if read, rdata <= readData;
    - done[g] <= 1 for one cycle;
    - gnt <= 0;
    - rr_ptr <= (g+1) mod NUM_REQ.
- Minimum turnaround: a requester whose req is still high on its done cycle is not re-granted until the following IDLE arbitration. It loses to any other eligible requester by rr_ptr order.
- Latched command: command fields are captured at grant. Requester changes after grant are ignored.
- Timeout: the counter clears on entry to ISSUE and BUSY and increments each cycle in those states. At count == TIMEOUT-1:
  - NewCommand <= 0, err <= 1, done[g] <= 1, gnt <= 0;
  - rdata is unchanged;
  - rr_ptr advances;
  - FSM goes to IDLE.
- init_mode:
  - Sampled only in IDLE.
  - Deasserting it mid-transaction does not affect the current transaction.
  - Asserting it while another requester is granted lets that transaction finish; requester 0 gets the next grant.
- Simultaneous requests: exactly one grant, chosen by the rr_ptr search. Ties cannot occur.
- Engine in a state other than Wait when arbiter is in IDLE: the grant proceeds. ISSUE does not see an accept until state leaves Wait, so it waits or times out.
- gnt and done are never asserted for more than one requester at a time.

Test Plan:
- Single read: req[1] with offset 0xC0, read; engine goes Wait -> Addr0 -> Read1 -> Read2 -> Wait with readData = 0x8870. Required: NewCommand high from cycle after req until state leaves Wait; done[1] pulses once; rdata = 0x8870; err = 0.
- Single write: req[2] with offset 0x92, wdata 0xFFFF. Required: offset = 0x92, WR = 1, writeData = 0xFFFF stable throughout ISSUE/BUSY; done[2] pulses; rdata unchanged.
- Round-robin: req = 3'b111 held continuously, each req dropped on its done. Required grant order 0, 1, 2; with req = 3'b011 held after that, next order 0, 1, 0, 1.
- init_mode = 1 with req = 3'b110. Required: no grant. Then req[0] asserted: grant 0 only. init_mode = 0: grants 1, 2 follow.
- Timeout: engine stuck in Wait ignoring NewCommand, TIMEOUT = 16. Required: done and err pulse together 16 cycles after issue; NewCommand low; arbiter serves next request normally.
- Reset asserted during BUSY. Required: next cycle all outputs 0, no done pulse; a fresh req is granted normally after reset is released.

Source files
------------

// File: rtl/eth_reg_arbiter.sv
// Round-robin arbiter sharing one KSZ8851 register-access engine among NUM_REQ requesters.
// Commands are latched at grant; completion is detected from the engine state code, with a watchdog abort.
module eth_reg_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  init_mode,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [8*NUM_REQ-1:0]  req_offset,
    input  logic [NUM_REQ-1:0]    req_length,
    input  logic [16*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  err,
    output logic [15:0]           rdata,
    output logic [7:0]            offset,
    output logic                  length,
    output logic                  WR,
    output logic [15:0]           writeData,
    output logic                  NewCommand,
    input  logic [3:0]            state,
    input  logic [15:0]           readData
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] ENG_WAIT = 4'd9;
    localparam logic [NUM_REQ-1:0] INIT_MASK = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                err_q, err_d;
    logic [15:0]         rdata_q, rdata_d;
    logic [7:0]          offset_q, offset_d;
    logic                length_q, length_d;
    logic                wr_q, wr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                newCmd_q, newCmd_d;
    logic [PW-1:0]       rrPtr_q, rrPtr_d;
    logic [PW-1:0]       grantIdx_q, grantIdx_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic [PW-1:0]       winner;
    logic [PW:0]         searchIdx;
    logic                selWr;
    logic                selLength;
    logic [7:0]          selOffset;
    logic [15:0]         selWdata;
    logic                timerExpired;
    logic                complete;
    logic                abort;
    logic [PW-1:0]       nextPtr;

    // The requester currently seeing its done pulse sits out this arbitration round.
    always_comb begin
        eligible = req & ~done_q;
        if (init_mode) begin
            eligible = eligible & INIT_MASK;
        end
        found     = 1'b0;
        winner    = '0;
        searchIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            searchIdx = {1'b0, rrPtr_q} + (PW+1)'(k);
            if (searchIdx >= (PW+1)'(NUM_REQ)) begin
                searchIdx = searchIdx - (PW+1)'(NUM_REQ);
            end
            if (!found && eligible[searchIdx[PW-1:0]]) begin
                found  = 1'b1;
                winner = searchIdx[PW-1:0];
            end
        end
    end

    always_comb begin
        selWr     = 1'b0;
        selLength = 1'b0;
        selOffset = '0;
        selWdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PW'(i)) begin
                selWr     = req_wr[i];
                selLength = req_length[i];
                selOffset = req_offset[8*i +: 8];
                selWdata  = req_wdata[16*i +: 16];
            end
        end
    end

    assign timerExpired = (timer_q == TW'(TIMEOUT-1));
    assign nextPtr      = (grantIdx_q == PW'(NUM_REQ-1)) ? '0 : grantIdx_q + 1'b1;

    always_comb begin
        fsm_d      = fsm_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        offset_d   = offset_q;
        length_d   = length_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        newCmd_d   = newCmd_q;
        rrPtr_d    = rrPtr_q;
        grantIdx_d = grantIdx_q;
        timer_d    = timer_q;
        complete   = 1'b0;
        abort      = 1'b0;

        unique case (fsm_q)
            IDLE: begin
                if (found) begin
                    grantIdx_d     = winner;
                    gnt_d          = '0;
                    gnt_d[winner]  = 1'b1;
                    wr_d           = selWr;
                    length_d       = selLength;
                    offset_d       = selOffset;
                    wdata_d        = selWr ? selWdata : 16'h0000;
                    newCmd_d       = 1'b1;
                    timer_d        = '0;
                    fsm_d          = ISSUE;
                end
            end
            ISSUE: begin
                if (state != ENG_WAIT) begin
                    newCmd_d = 1'b0;
                    timer_d  = '0;
                    fsm_d    = BUSY;
                end else if (timerExpired) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            BUSY: begin
                if (state == ENG_WAIT) begin
                    complete = 1'b1;
                    if (!wr_q) begin
                        rdata_d = readData;
                    end
                end else if (timerExpired) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        // Normal completion and watchdog abort share the same release path; abort adds err.
        if (complete || abort) begin
            done_d   = gnt_q;
            err_d    = abort;
            gnt_d    = '0;
            newCmd_d = 1'b0;
            rrPtr_d  = nextPtr;
            fsm_d    = IDLE;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            fsm_q      <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            offset_q   <= '0;
            length_q   <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            newCmd_q   <= 1'b0;
            rrPtr_q    <= '0;
            grantIdx_q <= '0;
            timer_q    <= '0;
        end else begin
            fsm_q      <= fsm_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            offset_q   <= offset_d;
            length_q   <= length_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            newCmd_q   <= newCmd_d;
            rrPtr_q    <= rrPtr_d;
            grantIdx_q <= grantIdx_d;
            timer_q    <= timer_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign offset     = offset_q;
    assign length     = length_q;
    assign WR         = wr_q;
    assign writeData  = wdata_q;
    assign NewCommand = newCmd_q;

endmodule

// File: tb/tb_eth_reg_arbiter.sv
// Directed bench for eth_reg_arbiter: a small behavioural KSZ8851 engine answers commands,
// and every transaction is checked against hand-computed grants, latencies and data.
module tb_eth_reg_arbiter;

    localparam logic [7:0]  OFF_TAB   [3] = '{8'h10, 8'hC0, 8'h92};
    localparam logic        WR_TAB    [3] = '{1'b0, 1'b0, 1'b1};
    localparam logic        LEN_TAB   [3] = '{1'b1, 1'b0, 1'b1};
    localparam logic [15:0] WDATA_TAB [3] = '{16'h0000, 16'h0000, 16'hFFFF};

    logic        sysclk;
    logic        reset;
    logic        init_mode;
    logic [2:0]  req;
    logic [2:0]  req_wr;
    logic [23:0] req_offset;
    logic [2:0]  req_length;
    logic [47:0] req_wdata;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        err;
    logic [15:0] rdata;
    logic [7:0]  offset;
    logic        length;
    logic        WR;
    logic [15:0] writeData;
    logic        NewCommand;
    logic [3:0]  state;
    logic [15:0] readData;

    logic        engStuck;
    logic [15:0] engReadVal;
    int          checkCount;
    int          errorCount;

    eth_reg_arbiter #(
        .NUM_REQ (3),
        .TIMEOUT (16),
        .TW      (5)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .init_mode  (init_mode),
        .req        (req),
        .req_wr     (req_wr),
        .req_offset (req_offset),
        .req_length (req_length),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .offset     (offset),
        .length     (length),
        .WR         (WR),
        .writeData  (writeData),
        .NewCommand (NewCommand),
        .state      (state),
        .readData   (readData)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Engine model: accepts a strobe seen in Wait, then walks Addr0 -> Read1/Write1 -> Read2/Write2 -> Wait.
    initial begin : engineModel
        logic ncSeen;
        logic wrSeen;
        logic engWr;
        state    = 4'd9;
        readData = 16'h0000;
        engWr    = 1'b0;
        forever begin
            @(negedge sysclk);
            ncSeen = NewCommand;
            wrSeen = WR;
            @(posedge sysclk);
            #1;
            case (state)
                4'd9: if (ncSeen && !engStuck) begin
                    state = 4'd0;
                    engWr = wrSeen;
                end
                4'd0: state = engWr ? 4'd7 : 4'd4;
                4'd4: state = 4'd5;
                4'd7: state = 4'd8;
                4'd5: begin
                    state    = 4'd9;
                    readData = engReadVal;
                end
                4'd8: begin
                    state    = 4'd9;
                    readData = 16'hDEAD;
                end
                default: state = 4'd9;
            endcase
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL globalTimeout: observed simulation still running, expected finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] reqVal, input logic initVal);
        req       = reqVal;
        init_mode = initVal;
    endtask

    // Steps negedges until a done pulse, checking the latched command while granted.
    task automatic runUntilDone(input string tag, input int budget, input int expIdx,
                                output int cycles, output int ncCycles,
                                output logic [2:0] doneObs, output logic errObs);
        int bad;
        cycles   = 0;
        ncCycles = 0;
        doneObs  = '0;
        errObs   = 1'b0;
        bad      = 0;
        while (cycles < budget && doneObs == 3'b000) begin
            @(negedge sysclk);
            cycles++;
            if (NewCommand) ncCycles++;
            if (gnt != 3'b000 &&
                (gnt != (3'b001 << expIdx) || offset != OFF_TAB[expIdx] || WR != WR_TAB[expIdx] ||
                 length != LEN_TAB[expIdx] || writeData != WDATA_TAB[expIdx])) begin
                bad++;
            end
            doneObs = done;
            errObs  = err;
        end
        checkOutput({tag, "_arrive"}, 32'(|doneObs), 32'd1);
        checkOutput({tag, "_stable"}, bad, 0);
    endtask

    int          cycles;
    int          ncCycles;
    logic [2:0]  doneObs;
    logic        errObs;
    logic [2:0]  reqNow;
    int          orderA [3] = '{0, 1, 2};
    int          orderB [4] = '{0, 1, 0, 1};
    int          stray;

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b1;
        engStuck   = 1'b0;
        engReadVal = 16'h0000;
        req_wr     = 3'b100;
        req_length = 3'b101;
        req_offset = 24'h92C010;
        req_wdata  = 48'hFFFF_ABCD_1357;
        applyStimulus(3'b000, 1'b0);

        repeat (3) @(negedge sysclk);
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_engine", {offset, length, WR, writeData, NewCommand}, 0);
        reset = 1'b0;
        repeat (2) @(negedge sysclk);

        // Single read from requester 1.
        engReadVal = 16'h8870;
        applyStimulus(3'b010, 1'b0);
        runUntilDone("rd", 20, 1, cycles, ncCycles, doneObs, errObs);
        checkOutput("rd_done", doneObs, 3'b010);
        checkOutput("rd_err", errObs, 0);
        checkOutput("rd_latency", cycles, 6);
        checkOutput("rd_newCmd", ncCycles, 2);
        checkOutput("rd_rdata", rdata, 16'h8870);
        checkOutput("rd_gntDrop", gnt, 0);
        applyStimulus(3'b000, 1'b0);
        @(negedge sysclk);
        checkOutput("rd_pulse", done, 0);

        // Single write from requester 2; rdata must keep the earlier read.
        applyStimulus(3'b100, 1'b0);
        runUntilDone("wr", 20, 2, cycles, ncCycles, doneObs, errObs);
        checkOutput("wr_done", doneObs, 3'b100);
        checkOutput("wr_err", errObs, 0);
        checkOutput("wr_latency", cycles, 6);
        checkOutput("wr_rdata", rdata, 16'h8870);
        applyStimulus(3'b000, 1'b0);

        // Round robin: all three, each dropped on its done.
        engReadVal = 16'h1111;
        reqNow = 3'b111;
        applyStimulus(reqNow, 1'b0);
        for (int n = 0; n < 3; n++) begin
            runUntilDone("rr3", 20, orderA[n], cycles, ncCycles, doneObs, errObs);
            checkOutput("rr3_order", doneObs, 3'b001 << orderA[n]);
            reqNow = reqNow & ~doneObs;
            applyStimulus(reqNow, 1'b0);
        end
        // Two held continuously must alternate.
        applyStimulus(3'b011, 1'b0);
        for (int n = 0; n < 4; n++) begin
            runUntilDone("rr2", 20, orderB[n], cycles, ncCycles, doneObs, errObs);
            checkOutput("rr2_order", doneObs, 3'b001 << orderB[n]);
            checkOutput("rr2_latency", cycles, 6);
        end
        applyStimulus(3'b000, 1'b0);
        checkOutput("rr_rdata", rdata, 16'h1111);

        // init_mode blocks everyone but requester 0.
        engReadVal = 16'h2222;
        applyStimulus(3'b110, 1'b1);
        stray = 0;
        repeat (10) begin
            @(negedge sysclk);
            if (gnt != 3'b000 || NewCommand) stray++;
        end
        checkOutput("init_block", stray, 0);
        applyStimulus(3'b111, 1'b1);
        runUntilDone("init0", 20, 0, cycles, ncCycles, doneObs, errObs);
        checkOutput("init0_done", doneObs, 3'b001);
        applyStimulus(3'b110, 1'b0);
        runUntilDone("init1", 20, 1, cycles, ncCycles, doneObs, errObs);
        checkOutput("init1_done", doneObs, 3'b010);
        applyStimulus(3'b100, 1'b0);
        runUntilDone("init2", 20, 2, cycles, ncCycles, doneObs, errObs);
        checkOutput("init2_done", doneObs, 3'b100);
        applyStimulus(3'b000, 1'b0);
        checkOutput("init_rdata", rdata, 16'h2222);

        // Watchdog: engine ignores the strobe.
        engStuck = 1'b1;
        applyStimulus(3'b010, 1'b0);
        runUntilDone("to", 40, 1, cycles, ncCycles, doneObs, errObs);
        checkOutput("to_done", doneObs, 3'b010);
        checkOutput("to_err", errObs, 1);
        checkOutput("to_latency", cycles, 17);
        checkOutput("to_newCmdCycles", ncCycles, 16);
        checkOutput("to_newCmdLow", NewCommand, 0);
        checkOutput("to_rdata", rdata, 16'h2222);
        engStuck   = 1'b0;
        engReadVal = 16'h5A5A;
        applyStimulus(3'b001, 1'b0);
        runUntilDone("post", 20, 0, cycles, ncCycles, doneObs, errObs);
        checkOutput("post_done", doneObs, 3'b001);
        checkOutput("post_err", errObs, 0);
        checkOutput("post_latency", cycles, 6);
        checkOutput("post_rdata", rdata, 16'h5A5A);
        applyStimulus(3'b000, 1'b0);
        @(negedge sysclk);
        checkOutput("post_errPulse", err, 0);

        // Reset while BUSY aborts silently.
        engReadVal = 16'h0BAD;
        applyStimulus(3'b001, 1'b0);
        repeat (3) @(negedge sysclk);
        checkOutput("mid_busy", {gnt, NewCommand}, {3'b001, 1'b0});
        reset = 1'b1;
        applyStimulus(3'b000, 1'b0);
        @(negedge sysclk);
        checkOutput("mid_gnt", gnt, 0);
        checkOutput("mid_done", {done, err}, 0);
        checkOutput("mid_rdata", rdata, 0);
        checkOutput("mid_engine", {offset, length, WR, writeData, NewCommand}, 0);
        @(negedge sysclk);
        reset = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge sysclk);
            if (done != 3'b000 || err) stray++;
        end
        checkOutput("mid_noDone", stray, 0);
        engReadVal = 16'h7E57;
        applyStimulus(3'b001, 1'b0);
        runUntilDone("fresh", 20, 0, cycles, ncCycles, doneObs, errObs);
        checkOutput("fresh_done", doneObs, 3'b001);
        checkOutput("fresh_latency", cycles, 6);
        checkOutput("fresh_rdata", rdata, 16'h7E57);
        applyStimulus(3'b000, 1'b0);
        @(negedge sysclk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
